// File: rtl/hitbox_detect.sv
// Circle-vs-box collision detector for two player hitboxes against the ball.
// Optional macro HITBOX_EXCLUSIVE_EN: when both players hit, flag only the nearer one (tie -> P1).
module hitbox_detect #(
  parameter int BALL_R   = 40,
  parameter int PLAYER_W = 128,
  parameter int PLAYER_H = 128,
  parameter int INSET    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [9:0] p1_pos_x,
  input  logic [9:0] p1_pos_y,
  input  logic [9:0] p2_pos_x,
  input  logic [9:0] p2_pos_y,
  input  logic [9:0] ball_pos_x,
  input  logic [9:0] ball_pos_y,
  output logic       p1_cover,
  output logic       p2_cover,
  output logic       done,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [3:0] {
    IDLE, CLAMP1, SQX1, SQY1, CMP1, CLAMP2, SQX2, SQY2, CMP2, UPDATE
  } state_t;

  localparam logic signed [11:0] R_S   = 12'(BALL_R);
  localparam logic signed [11:0] LO_S  = 12'(INSET);
  localparam logic signed [11:0] XHI_S = 12'(PLAYER_W - 1 - INSET);
  localparam logic signed [11:0] YHI_S = 12'(PLAYER_H - 1 - INSET);
  localparam logic [23:0]        R_SQ  = 24'(BALL_R * BALL_R);

  state_t state, state_next;

  logic [9:0] s_p1x, s_p1y, s_p2x, s_p2y, s_bx, s_by;
  logic signed [11:0] dx, dy;
  logic [23:0] acc;
  logic hit1, hit2;
`ifdef HITBOX_EXCLUSIVE_EN
  logic [23:0] dist1, dist2;
`endif

  logic signed [11:0] cx, cy, px, py, x0, x1, y0, y1, qx, qy, mul_op;
  logic signed [23:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (valid) state_next = CLAMP1;
      CLAMP1:  state_next = SQX1;
      SQX1:    state_next = SQY1;
      SQY1:    state_next = CMP1;
      CMP1:    state_next = CLAMP2;
      CLAMP2:  state_next = SQX2;
      SQX2:    state_next = SQY2;
      SQY2:    state_next = CMP2;
      CMP2:    state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Clamp ball centre into the active player's box; one multiplier squares dx then dy.
  always_comb begin
    cx = signed'({2'b00, s_bx}) + R_S;
    cy = signed'({2'b00, s_by}) + R_S;
    if (state == CLAMP2) begin
      px = signed'({2'b00, s_p2x});
      py = signed'({2'b00, s_p2y});
    end else begin
      px = signed'({2'b00, s_p1x});
      py = signed'({2'b00, s_p1y});
    end
    x0 = px + LO_S;
    x1 = px + XHI_S;
    y0 = py + LO_S;
    y1 = py + YHI_S;
    qx = cx;
    if (cx < x0)      qx = x0;
    else if (cx > x1) qx = x1;
    qy = cy;
    if (cy < y0)      qy = y0;
    else if (cy > y1) qy = y1;
    mul_op = (state == SQY1 || state == SQY2) ? dy : dx;
    prod   = mul_op * mul_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p1x <= '0; s_p1y <= '0; s_p2x <= '0; s_p2y <= '0; s_bx <= '0; s_by <= '0;
      dx <= '0; dy <= '0; acc <= '0; hit1 <= 1'b0; hit2 <= 1'b0;
`ifdef HITBOX_EXCLUSIVE_EN
      dist1 <= '0; dist2 <= '0;
`endif
      p1_cover <= 1'b0; p2_cover <= 1'b0; done <= 1'b0; overrun <= 1'b0;
    end else begin
      done    <= (state == UPDATE);
      overrun <= valid && (state != IDLE);
      case (state)
        IDLE: if (valid) begin
          s_p1x <= p1_pos_x; s_p1y <= p1_pos_y;
          s_p2x <= p2_pos_x; s_p2y <= p2_pos_y;
          s_bx  <= ball_pos_x; s_by <= ball_pos_y;
        end
        CLAMP1, CLAMP2: begin
          dx <= cx - qx;
          dy <= cy - qy;
        end
        SQX1, SQX2: acc <= unsigned'(prod);
        SQY1, SQY2: acc <= acc + unsigned'(prod);
        CMP1: begin
          hit1 <= (acc <= R_SQ);
`ifdef HITBOX_EXCLUSIVE_EN
          dist1 <= acc;
`endif
        end
        CMP2: begin
          hit2 <= (acc <= R_SQ);
`ifdef HITBOX_EXCLUSIVE_EN
          dist2 <= acc;
`endif
        end
        UPDATE: begin
`ifdef HITBOX_EXCLUSIVE_EN
          if (hit1 && hit2) begin
            p1_cover <= (dist1 <= dist2);
            p2_cover <= (dist1 > dist2);
          end else begin
            p1_cover <= hit1;
            p2_cover <= hit2;
          end
`else
          p1_cover <= hit1;
          p2_cover <= hit2;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hitbox_detect.sv
// Self-checking bench for hitbox_detect: directed scenarios plus random frames against a geometric model.
module tb_hitbox_detect;
  localparam int R  = 40;
  localparam int W  = 128;
  localparam int H  = 128;
  localparam int IN = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic valid;
  logic [9:0] p1_pos_x, p1_pos_y, p2_pos_x, p2_pos_y, ball_pos_x, ball_pos_y;
  logic p1_cover, p2_cover, done, busy, overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hitbox_detect dut (
    .clk(clk), .rst_n(rst_n), .valid(valid),
    .p1_pos_x(p1_pos_x), .p1_pos_y(p1_pos_y),
    .p2_pos_x(p2_pos_x), .p2_pos_y(p2_pos_y),
    .ball_pos_x(ball_pos_x), .ball_pos_y(ball_pos_y),
    .p1_cover(p1_cover), .p2_cover(p2_cover),
    .done(done), .busy(busy), .overrun(overrun)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Squared distance from ball centre to the nearest point of the shrunken player box.
  function automatic int dist2(input int px, input int py, input int bx, input int by);
    int cx, cy, dx, dy;
    cx = bx + R;
    cy = by + R;
    dx = cx - clampi(cx, px + IN, px + W - 1 - IN);
    dy = cy - clampi(cy, py + IN, py + H - 1 - IN);
    return dx * dx + dy * dy;
  endfunction

  task automatic expect_flags(input int a1x, a1y, a2x, a2y, bx, by, output int e1, output int e2);
    int d1, d2;
    d1 = dist2(a1x, a1y, bx, by);
    d2 = dist2(a2x, a2y, bx, by);
    e1 = (d1 <= R * R) ? 1 : 0;
    e2 = (d2 <= R * R) ? 1 : 0;
`ifdef HITBOX_EXCLUSIVE_EN
    if (e1 == 1 && e2 == 1) begin
      if (d1 <= d2) e2 = 0;
      else          e1 = 0;
    end
`endif
  endtask

  task automatic set_pos(input int a1x, a1y, a2x, a2y, bx, by);
    p1_pos_x = 10'(a1x); p1_pos_y = 10'(a1y);
    p2_pos_x = 10'(a2x); p2_pos_y = 10'(a2y);
    ball_pos_x = 10'(bx); ball_pos_y = 10'(by);
  endtask

  // Issues one frame with the currently driven positions and checks latency, handshake and flags.
  task automatic run_frame(input string tag);
    int e1, e2, n;
    expect_flags(int'(p1_pos_x), int'(p1_pos_y), int'(p2_pos_x), int'(p2_pos_y),
                 int'(ball_pos_x), int'(ball_pos_y), e1, e2);
    @(negedge clk) valid = 1'b1;
    @(negedge clk) valid = 1'b0;
    check({tag, ".busy"}, int'(busy), 1);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, 9);
    check({tag, ".p1"}, int'(p1_cover), e1);
    check({tag, ".p2"}, int'(p2_cover), e2);
    @(negedge clk);
    check({tag, ".done_width"}, int'(done), 0);
    check({tag, ".busy_fall"}, int'(busy), 0);
  endtask

  initial begin
    int e1, e2, n_ovr, n_done, bx, by, a1x, a1y, a2x, a2y;
    rst_n = 1'b0;
    valid = 1'b0;
    set_pos(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst.p1", int'(p1_cover), 0);
    check("rst.p2", int'(p2_cover), 0);
    check("rst.done", int'(done), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.overrun", int'(overrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    set_pos(100, 352, 800, 0, 140, 300);
    run_frame("head_hit");
    set_pos(100, 352, 800, 0, 140, 250);
    run_frame("miss");
    set_pos(100, 352, 800, 0, 44, 288);
    run_frame("corner");
    set_pos(180, 352, 332, 352, 280, 340);
    run_frame("dual");

    // Second valid four edges after the first must be ignored with a single overrun pulse.
    set_pos(100, 352, 800, 0, 140, 300);
    expect_flags(100, 352, 800, 0, 140, 300, e1, e2);
    @(negedge clk) valid = 1'b1;
    @(negedge clk) valid = 1'b0;
    repeat (3) @(negedge clk);
    set_pos(100, 352, 800, 0, 600, 20);
    valid = 1'b1;
    n_ovr = 0;
    n_done = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      valid = 1'b0;
      if (overrun) n_ovr++;
      if (done) n_done++;
    end
    check("ovr.pulses", n_ovr, 1);
    check("ovr.done_pulses", n_done, 1);
    check("ovr.p1", int'(p1_cover), e1);
    check("ovr.p2", int'(p2_cover), e2);

    // valid coinciding with UPDATE is treated as busy.
    set_pos(100, 352, 800, 0, 140, 250);
    @(negedge clk) valid = 1'b1;
    @(negedge clk) valid = 1'b0;
    repeat (8) @(negedge clk);
    valid = 1'b1;
    @(negedge clk) valid = 1'b0;
    check("upd.overrun", int'(overrun), 1);
    check("upd.done", int'(done), 1);
    check("upd.p1", int'(p1_cover), 0);
    @(negedge clk);
    check("upd.idle", int'(busy), 0);

    // Reset mid-evaluation of a hitting frame.
    set_pos(100, 352, 800, 0, 140, 300);
    @(negedge clk) valid = 1'b1;
    @(negedge clk) valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", int'(busy), 0);
    check("midrst.p1", int'(p1_cover), 0);
    @(negedge clk) rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst.no_done", n_done, 0);
    check("midrst.p1_held", int'(p1_cover), 0);
    run_frame("after_rst");

    for (int k = 0; k < 24; k++) begin
      a1x = $urandom_range(0, 800);
      a1y = $urandom_range(0, 800);
      a2x = $urandom_range(0, 800);
      a2y = $urandom_range(0, 800);
      if (k % 2 == 0) begin
        bx = clampi(a1x + $urandom_range(0, 200) - 100, 0, 1023);
        by = clampi(a1y + $urandom_range(0, 200) - 100, 0, 1023);
      end else begin
        bx = clampi(a2x + $urandom_range(0, 200) - 100, 0, 1023);
        by = clampi(a2y + $urandom_range(0, 200) - 100, 0, 1023);
      end
      if (k % 6 == 5) begin
        a2x = clampi(a1x + $urandom_range(0, 40), 0, 1023);
        a2y = a1y;
      end
      set_pos(a1x, a1y, a2x, a2y, bx, by);
      run_frame($sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
